// File: rtl/sgdmac_bd_loader.sv
// sgdmac_bd_loader
// Host-side command sequencer in front of the SGDMA controller's Wishbone
// slave port. Commands from a local stream are queued in a FIFO and issued
// one at a time as classic Wishbone cycles. Each command yields exactly one
// response (read data, slave error or timeout). Slave errors and timeouts
// are tallied in a saturating 8-bit counter.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (cmd_ready = FIFO not full)
//   cmd_we/addr/data/sel      command payload
//   rsp_valid/rsp_ready       response handshake
//   rsp_data/rsp_err/rsp_tmo  response payload
//   saddr/swdat/ssel/swe      Wishbone request fields (held for the cycle)
//   scyc/sstb                 Wishbone cycle / strobe
//   srdat/sack/serr           Wishbone read data and terminations
//   busy                      FIFO non-empty or sequencer active
//   err_cnt                   saturating serr + timeout count
module sgdmac_bd_loader #(
    parameter int AWIDTH     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [31:0]       cmd_data,
    input  logic [3:0]        cmd_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              rsp_tmo,
    output logic [AWIDTH-1:0] saddr,
    output logic [31:0]       swdat,
    input  logic [31:0]       srdat,
    output logic              scyc,
    output logic              sstb,
    output logic [3:0]        ssel,
    output logic              swe,
    input  logic              sack,
    input  logic              serr,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = 1 + AWIDTH + 32 + 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [PW:0] DEPTH_C  = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0] ONE_C    = (PW + 1)'(1);

    logic [EW-1:0]     mem_r [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW:0]       count_r;
    logic [PW:0]       count_nxt_s;
    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [7:0]        tmo_cnt_r;

    logic              push_s;
    logic              pop_s;
    logic [EW-1:0]     head_s;
    logic              bus_err_s;
    logic              bus_ack_s;
    logic              bus_tmo_s;
    logic              term_s;

    assign push_s = cmd_valid & cmd_ready;
    assign pop_s  = (state_r == ST_IDLE) && (count_r != '0);
    assign head_s = mem_r[rd_ptr_r];

    // Terminations in priority order: serr beats sack, both beat the timeout.
    assign bus_err_s = (state_r == ST_BUS) && serr;
    assign bus_ack_s = (state_r == ST_BUS) && !serr && sack;
    assign bus_tmo_s = (state_r == ST_BUS) && !serr && !sack && (tmo_cnt_r == TMO_LAST);
    assign term_s    = bus_err_s | bus_ack_s | bus_tmo_s;

    // FIFO occupancy after this edge; also feeds the registered ready/busy flags.
    always_comb begin
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + ONE_C;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - ONE_C;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Sequencer next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) state_nxt_s = ST_BUS;
                else       state_nxt_s = ST_IDLE;
            end
            ST_BUS: begin
                if (term_s) state_nxt_s = ST_RSP;
                else        state_nxt_s = ST_BUS;
            end
            ST_RSP: begin
                if (rsp_ready) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_RSP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FIFO storage; flushing is done by resetting the pointers, not the array.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {cmd_we, cmd_addr, cmd_data, cmd_sel};
        end
    end

    // FIFO pointers, sequencer state, Wishbone request and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            state_r   <= ST_IDLE;
            tmo_cnt_r <= 8'd0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
            rsp_err   <= 1'b0;
            rsp_tmo   <= 1'b0;
            saddr     <= '0;
            swdat     <= 32'h0;
            ssel      <= 4'h0;
            swe       <= 1'b0;
            scyc      <= 1'b0;
            sstb      <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            count_r   <= count_nxt_s;
            cmd_ready <= (count_nxt_s != DEPTH_C);
            busy      <= (count_nxt_s != '0) || (state_nxt_s != ST_IDLE);
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);

            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        swe       <= head_s[EW-1];
                        saddr     <= head_s[36 +: AWIDTH];
                        swdat     <= head_s[35:4];
                        ssel      <= head_s[3:0];
                        scyc      <= 1'b1;
                        sstb      <= 1'b1;
                        tmo_cnt_r <= 8'd0;
                    end
                end
                ST_BUS: begin
                    if (term_s) begin
                        scyc      <= 1'b0;
                        sstb      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= bus_err_s;
                        rsp_tmo   <= bus_tmo_s;
                        // Only a successful read returns data.
                        rsp_data  <= (bus_ack_s && !swe) ? srdat : 32'h0;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_tmo   <= 1'b0;
                    end
                end
                default: begin
                    scyc <= 1'b0;
                    sstb <= 1'b0;
                end
            endcase

            if ((bus_err_s || bus_tmo_s) && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sgdmac_bd_loader.sv
// Bench for sgdmac_bd_loader. A slave model decides its behaviour from the
// address: addr[3:2] = 0/1 ack, 2 serr+sack, 3 silent; wait states = ~addr[5:4].
// Observed bus cycles and responses are logged into queues and compared with
// a transaction-level model of the expected results.
module tb_sgdmac_bd_loader;

    localparam int TMO = 8;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } cmd_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        int          len;
        bit          stable;
        time         t_rise;
    } acc_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        tmo;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_data;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo;
    logic [31:0] rsp_data;
    logic [31:0] saddr, swdat, srdat;
    logic        scyc, sstb, swe, sack, serr, busy;
    logic [3:0]  ssel;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 1;   // 0 hold low, 1 hold high, 2 random

    cmd_t sent_q[$];
    time  acc_t_q[$];
    acc_t acc_q[$];
    rsp_t rsp_q[$];

    always #5 clk = ~clk;

    sgdmac_bd_loader #(.AWIDTH(32), .FIFO_DEPTH(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
        .saddr(saddr), .swdat(swdat), .srdat(srdat), .scyc(scyc), .sstb(sstb),
        .ssel(ssel), .swe(swe), .sack(sack), .serr(serr),
        .busy(busy), .err_cnt(err_cnt)
    );

    function automatic logic [31:0] rdata_of(logic [31:0] a);
        if (a == 32'h4) return 32'h1234_5678;
        else            return {a[15:0] ^ 16'h5A5A, a[31:16]};
    endfunction

    function automatic rsp_t model_rsp(cmd_t c);
        rsp_t r;
        r.err  = (c.addr[3:2] == 2'd2);
        r.tmo  = (c.addr[3:2] == 2'd3);
        r.data = (r.err || r.tmo || c.we) ? 32'h0 : rdata_of(c.addr);
        return r;
    endfunction

    function automatic int model_len(cmd_t c);
        logic [1:0] w;
        w = ~c.addr[5:4];
        if (c.addr[3:2] == 2'd3) return TMO;
        else                     return int'(w) + 1;
    endfunction

    // rsp_ready driver
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 2) rsp_ready = 1'($urandom_range(0, 1));
            else               rsp_ready = (rdy_mode == 1);
        end
    end

    // Slave model and bus/response monitor
    initial begin
        int         bus_cnt;
        acc_t       cur;
        logic [1:0] wt;
        bit         hit;
        bus_cnt = 0;
        sack = 1'b0; serr = 1'b0; srdat = 32'h0BAD_0BAD;
        cur = '{we: 1'b0, addr: 32'h0, wdat: 32'h0, sel: 4'h0, len: 0, stable: 1'b1, t_rise: 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                bus_cnt = 0; sack = 1'b0; serr = 1'b0;
            end else begin
                if (rsp_valid && rsp_ready)
                    rsp_q.push_back('{data: rsp_data, err: rsp_err, tmo: rsp_tmo});
                if (scyc) begin
                    if (bus_cnt == 0) begin
                        cur.we = swe; cur.addr = saddr; cur.wdat = swdat; cur.sel = ssel;
                        cur.stable = sstb; cur.t_rise = $time;
                    end else if (cur.we !== swe || cur.addr !== saddr || cur.wdat !== swdat ||
                                 cur.sel !== ssel || !sstb) begin
                        cur.stable = 1'b0;
                    end
                    bus_cnt++;
                    wt  = ~cur.addr[5:4];
                    hit = (cur.addr[3:2] != 2'd3) && (bus_cnt == int'(wt) + 1);
                    sack  = hit;
                    serr  = hit && (cur.addr[3:2] == 2'd2);
                    srdat = hit ? rdata_of(cur.addr) : 32'h0BAD_0BAD;
                end else begin
                    if (bus_cnt != 0) begin
                        cur.len = bus_cnt;
                        acc_q.push_back(cur);
                    end
                    bus_cnt = 0; sack = 1'b0; serr = 1'b0;
                end
            end
        end
    end

    task automatic clear_q();
        sent_q.delete(); acc_t_q.delete(); acc_q.delete(); rsp_q.delete();
    endtask

    task automatic push_cmd(input cmd_t c);
        bit ok;
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_we = c.we; cmd_addr = c.addr; cmd_data = c.data; cmd_sel = c.sel;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_accept: cmd_ready stayed 0, required 1 within 2000 cycles");
        end else begin
            @(posedge clk);
            acc_t_q.push_back($time);
            sent_q.push_back(c);
        end
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_wait: busy=%0b rsp_valid=%0b after %0d cycles, required 0/0", busy, rsp_valid, budget);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %0b exp 0", cmd_ready); end
        checks++; if ({rsp_valid, rsp_err, rsp_tmo, scyc, sstb, swe, busy} !== 7'b0) begin
            errors++; $display("FAIL rst_flags: got %07b exp 0000000", {rsp_valid, rsp_err, rsp_tmo, scyc, sstb, swe, busy}); end
        checks++; if ({rsp_data, saddr, swdat, ssel, err_cnt} !== 108'h0) begin
            errors++; $display("FAIL rst_values: data %0h addr %0h wdat %0h sel %0h err_cnt %0d, exp all 0", rsp_data, saddr, swdat, ssel, err_cnt); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0b exp 1", cmd_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_write();
        cmd_t c;
        clear_q();
        c = '{we: 1'b1, addr: 32'h0000_0010, data: 32'hDEAD_BEEF, sel: 4'hF};
        push_cmd(c);
        wait_idle(200);
        checks++;
        if (acc_q.size() != 1 || rsp_q.size() != 1) begin
            errors++; $display("FAIL wr_count: acc %0d rsp %0d exp 1 1", acc_q.size(), rsp_q.size());
        end else begin
            checks++; if (acc_q[0].len != 3) begin errors++; $display("FAIL wr_len: got %0d exp 3", acc_q[0].len); end
            checks++; if (acc_q[0].we !== 1'b1 || acc_q[0].wdat !== 32'hDEAD_BEEF || acc_q[0].addr !== 32'h10 || acc_q[0].sel !== 4'hF) begin
                errors++; $display("FAIL wr_fields: we %0b wdat %0h addr %0h sel %0h exp 1 deadbeef 10 f", acc_q[0].we, acc_q[0].wdat, acc_q[0].addr, acc_q[0].sel); end
            checks++; if (!acc_q[0].stable) begin errors++; $display("FAIL wr_stable: got 0 exp 1"); end
            checks++; if (acc_q[0].t_rise != acc_t_q[0] + 15) begin
                errors++; $display("FAIL wr_latency: scyc seen at %0t exp %0t", acc_q[0].t_rise, acc_t_q[0] + 15); end
            checks++; if (rsp_q[0].data !== 32'h0 || rsp_q[0].err !== 1'b0 || rsp_q[0].tmo !== 1'b0) begin
                errors++; $display("FAIL wr_rsp: data %0h err %0b tmo %0b exp 0 0 0", rsp_q[0].data, rsp_q[0].err, rsp_q[0].tmo); end
        end
    endtask

    task automatic test_read();
        cmd_t c;
        clear_q();
        c = '{we: 1'b0, addr: 32'h0000_0004, data: 32'hFFFF_FFFF, sel: 4'hF};
        push_cmd(c);
        wait_idle(200);
        checks++;
        if (acc_q.size() != 1 || rsp_q.size() != 1) begin
            errors++; $display("FAIL rd_count: acc %0d rsp %0d exp 1 1", acc_q.size(), rsp_q.size());
        end else begin
            checks++; if (acc_q[0].we !== 1'b0 || acc_q[0].len != model_len(c)) begin
                errors++; $display("FAIL rd_bus: we %0b len %0d exp 0 %0d", acc_q[0].we, acc_q[0].len, model_len(c)); end
            checks++; if (rsp_q[0].data !== 32'h1234_5678 || rsp_q[0].err !== 1'b0 || rsp_q[0].tmo !== 1'b0) begin
                errors++; $display("FAIL rd_rsp: data %0h err %0b tmo %0b exp 12345678 0 0", rsp_q[0].data, rsp_q[0].err, rsp_q[0].tmo); end
        end
    endtask

    task automatic test_error_timeout();
        cmd_t c;
        clear_q();
        c = '{we: 1'b0, addr: 32'h0000_0008, data: 32'h0, sel: 4'hF};
        push_cmd(c);
        wait_idle(200);
        checks++; if (rsp_q.size() != 1 || rsp_q[0].err !== 1'b1 || rsp_q[0].tmo !== 1'b0 || rsp_q[0].data !== 32'h0) begin
            errors++; $display("FAIL serr_rsp: count %0d, exp one response err=1 tmo=0 data=0", rsp_q.size()); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL serr_cnt: got %0d exp 1", err_cnt); end
        clear_q();
        c = '{we: 1'b0, addr: 32'h0000_000C, data: 32'h0, sel: 4'hF};
        push_cmd(c);
        wait_idle(200);
        checks++; if (acc_q.size() != 1 || acc_q[0].len != TMO) begin
            errors++; $display("FAIL tmo_len: count %0d, exp one cycle of %0d", acc_q.size(), TMO); end
        checks++; if (rsp_q.size() != 1 || rsp_q[0].tmo !== 1'b1 || rsp_q[0].err !== 1'b0 || rsp_q[0].data !== 32'h0) begin
            errors++; $display("FAIL tmo_rsp: count %0d, exp one response tmo=1 err=0 data=0", rsp_q.size()); end
        checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL tmo_cnt: got %0d exp 2", err_cnt); end
        clear_q();
        for (int i = 0; i < 300; i++) begin
            c = '{we: 1'($urandom_range(0, 1)), addr: ($urandom & 32'hFFFF_FFF0) | 32'hC, data: $urandom, sel: 4'hF};
            push_cmd(c);
        end
        wait_idle(8000);
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt: got %0d exp 255", err_cnt); end
        checks++;
        if (rsp_q.size() != 300) begin
            errors++; $display("FAIL sat_rsp_count: got %0d exp 300", rsp_q.size());
        end else begin
            for (int i = 0; i < 300; i++) begin
                checks++; if (rsp_q[i].tmo !== 1'b1 || rsp_q[i].data !== 32'h0) begin
                    errors++; $display("FAIL sat_rsp[%0d]: tmo %0b data %0h exp 1 0", i, rsp_q[i].tmo, rsp_q[i].data); end
            end
        end
    endtask

    task automatic test_backpressure();
        cmd_t c;
        rsp_t snap, exp_r;
        bit   seen;
        time  t_pos;
        clear_q();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            c = '{we: 1'b0, addr: $urandom & 32'hFFFF_FFF3, data: $urandom, sel: 4'($urandom)};
            push_cmd(c);
        end
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_rsp_valid: got 0 exp 1 within 100 cycles"); end
        snap = '{data: rsp_data, err: rsp_err, tmo: rsp_tmo};
        exp_r = model_rsp(sent_q[0]);
        checks++; if (snap.data !== exp_r.data || snap.err !== exp_r.err || snap.tmo !== exp_r.tmo) begin
            errors++; $display("FAIL bp_first: data %0h exp %0h", snap.data, exp_r.data); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (!rsp_valid || rsp_data !== snap.data || rsp_err !== snap.err || rsp_tmo !== snap.tmo || scyc) begin
                errors++; $display("FAIL bp_hold[%0d]: valid %0b data %0h scyc %0b exp 1 %0h 0", i, rsp_valid, rsp_data, scyc, snap.data); end
        end
        rdy_mode = 1;
        @(posedge clk);
        t_pos = $time;
        wait_idle(200);
        checks++;
        if (acc_q.size() != 2 || rsp_q.size() != 2) begin
            errors++; $display("FAIL bp_count: acc %0d rsp %0d exp 2 2", acc_q.size(), rsp_q.size());
        end else begin
            checks++; if (acc_q[1].t_rise != t_pos + 25) begin
                errors++; $display("FAIL bp_next_scyc: at %0t exp %0t", acc_q[1].t_rise, t_pos + 25); end
            exp_r = model_rsp(sent_q[1]);
            checks++; if (rsp_q[1].data !== exp_r.data) begin
                errors++; $display("FAIL bp_second: data %0h exp %0h", rsp_q[1].data, exp_r.data); end
        end
    endtask

    task automatic test_fill();
        cmd_t c;
        rsp_t exp_r;
        clear_q();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            c = '{we: 1'($urandom_range(0, 1)), addr: $urandom & 32'hFFFF_FFF7, data: $urandom, sel: 4'($urandom)};
            push_cmd(c);
        end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL fill_full: cmd_ready %0b exp 0", cmd_ready); end
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b0 || rsp_q.size() != 0) begin
            errors++; $display("FAIL fill_hold: cmd_ready %0b rsp %0d exp 0 0", cmd_ready, rsp_q.size()); end
        rdy_mode = 1;
        wait_idle(400);
        checks++;
        if (acc_q.size() != 17 || rsp_q.size() != 17) begin
            errors++; $display("FAIL fill_count: acc %0d rsp %0d exp 17 17", acc_q.size(), rsp_q.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                exp_r = model_rsp(sent_q[i]);
                checks++; if (acc_q[i].addr !== sent_q[i].addr || acc_q[i].we !== sent_q[i].we ||
                              acc_q[i].wdat !== sent_q[i].data || acc_q[i].sel !== sent_q[i].sel) begin
                    errors++; $display("FAIL fill_acc[%0d]: addr %0h exp %0h", i, acc_q[i].addr, sent_q[i].addr); end
                checks++; if (rsp_q[i].data !== exp_r.data || rsp_q[i].err !== exp_r.err || rsp_q[i].tmo !== exp_r.tmo) begin
                    errors++; $display("FAIL fill_rsp[%0d]: data %0h exp %0h", i, rsp_q[i].data, exp_r.data); end
            end
        end
    endtask

    task automatic test_reset_mid_bus();
        cmd_t c;
        clear_q();
        for (int i = 0; i < 4; i++) begin
            c = '{we: 1'b1, addr: 32'h0000_000C | (32'(i) << 8), data: $urandom, sel: 4'hF};
            push_cmd(c);
        end
        @(negedge clk);
        checks++; if (scyc !== 1'b1) begin errors++; $display("FAIL rmb_scyc_before: got %0b exp 1", scyc); end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (scyc !== 1'b0 || sstb !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL rmb_after_edge: scyc %0b sstb %0b busy %0b rsp_valid %0b cmd_ready %0b exp 0 0 0 0 0", scyc, sstb, busy, rsp_valid, cmd_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
        clear_q();
        repeat (20) @(negedge clk);
        checks++; if (acc_q.size() != 0 || rsp_q.size() != 0 || busy !== 1'b0 || err_cnt !== 8'd0) begin
            errors++; $display("FAIL rmb_flushed: acc %0d rsp %0d busy %0b err_cnt %0d exp 0 0 0 0", acc_q.size(), rsp_q.size(), busy, err_cnt); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        cmd_t c;
        rsp_t exp_r;
        int   exp_err;
        clear_q();
        exp_err = 0;
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            c = '{we: 1'($urandom_range(0, 1)), addr: $urandom, data: $urandom, sel: 4'($urandom)};
            if (c.addr[3:2] >= 2'd2 && exp_err < 255) exp_err++;
            push_cmd(c);
        end
        wait_idle(6000);
        rdy_mode = 1;
        checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL rnd_err_cnt: got %0d exp %0d", err_cnt, exp_err); end
        checks++;
        if (acc_q.size() != 40 || rsp_q.size() != 40) begin
            errors++; $display("FAIL rnd_count: acc %0d rsp %0d exp 40 40", acc_q.size(), rsp_q.size());
        end else begin
            for (int i = 0; i < 40; i++) begin
                exp_r = model_rsp(sent_q[i]);
                checks++; if (acc_q[i].addr !== sent_q[i].addr || acc_q[i].we !== sent_q[i].we || acc_q[i].wdat !== sent_q[i].data ||
                              acc_q[i].sel !== sent_q[i].sel || acc_q[i].len != model_len(sent_q[i]) || !acc_q[i].stable) begin
                    errors++; $display("FAIL rnd_acc[%0d]: addr %0h len %0d exp %0h %0d", i, acc_q[i].addr, acc_q[i].len, sent_q[i].addr, model_len(sent_q[i])); end
                checks++; if (rsp_q[i].data !== exp_r.data || rsp_q[i].err !== exp_r.err || rsp_q[i].tmo !== exp_r.tmo) begin
                    errors++; $display("FAIL rnd_rsp[%0d]: data %0h err %0b tmo %0b exp %0h %0b %0b", i, rsp_q[i].data, rsp_q[i].err, rsp_q[i].tmo, exp_r.data, exp_r.err, exp_r.tmo); end
            end
        end
    endtask

    task automatic test_back_to_back();
        cmd_t c;
        clear_q();
        for (int i = 0; i < 4; i++) begin
            c = '{we: 1'($urandom_range(0, 1)), addr: ($urandom & 32'hFFFF_FFC3) | 32'h30, data: $urandom, sel: 4'hF};
            push_cmd(c);
        end
        wait_idle(200);
        checks++;
        if (acc_q.size() != 4) begin
            errors++; $display("FAIL b2b_count: got %0d exp 4", acc_q.size());
        end else begin
            checks++; if (acc_q[0].t_rise != acc_t_q[0] + 15) begin
                errors++; $display("FAIL b2b_latency: at %0t exp %0t", acc_q[0].t_rise, acc_t_q[0] + 15); end
            for (int i = 1; i < 4; i++) begin
                checks++; if (acc_q[i].len != 1 || acc_q[i].t_rise != acc_q[i-1].t_rise + 30) begin
                    errors++; $display("FAIL b2b_spacing[%0d]: len %0d gap %0t exp 1 30", i, acc_q[i].len, acc_q[i].t_rise - acc_q[i-1].t_rise); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_data = 32'h0; cmd_sel = 4'h0;
        test_reset();
        test_single_write();
        test_read();
        test_error_timeout();
        test_backpressure();
        test_fill();
        test_reset_mid_bus();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
